// File: rtl/fadd_seq_pkg.sv
// Shared constants and types for the byte-serial float32 adder front end.
package fadd_seq_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EXEC,
        SEND
    } state_e;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(NBYTES - 1);

endpackage

// File: rtl/float32_adder.sv
// Combinational float32 "adder": keeps A's sign/exponent, sums the fractions modulo 2^23.
module float32_adder
    import fadd_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [WORD_W-1:0] sum_o
);

    assign sum_o = {a_i[31:23], a_i[22:0] + b_i[22:0]};

endmodule

// File: rtl/fadd_byte_sequencer.sv
// Byte-serial front end: loads A and B a byte at a time, fires float32_adder,
// streams the registered result back little-endian, with optional accumulate.
//
// state  | meaning
// LOAD_A | collecting A bytes, or pulling A from the accumulator (idle when count==0)
// LOAD_B | collecting B bytes
// EXEC   | single cycle: capture adder output into result and accumulator
// SEND   | presenting result bytes to the consumer
module fadd_byte_sequencer
    import fadd_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              acc_mode,
    input  logic              acc_clr,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_e            state_q;
    cnt_t              cnt_q;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] res_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] sum;
    logic              acc_take;
    logic              in_xfer;
    logic              out_xfer;

    float32_adder u_adder (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (sum)
    );

    // acc_mode only matters at the very start of a transaction
    assign acc_take  = (state_q == LOAD_A) && (cnt_q == '0) && acc_mode;
    assign in_ready  = ((state_q == LOAD_A) && !acc_take) || (state_q == LOAD_B);
    assign out_valid = (state_q == SEND);
    assign busy      = !((state_q == LOAD_A) && (cnt_q == '0));
    assign out_data  = out_valid ? res_q[BYTE_W*cnt_q +: BYTE_W] : '0;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            acc_q   <= '0;
        end else begin
            if (acc_clr) begin
                acc_q <= '0;
            end
            case (state_q)
                LOAD_A: begin
                    if (acc_take) begin
                        a_q     <= acc_q;
                        state_q <= LOAD_B;
                    end else if (in_xfer) begin
                        a_q[BYTE_W*cnt_q +: BYTE_W] <= in_data;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        b_q[BYTE_W*cnt_q +: BYTE_W] <= in_data;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // placed after the clear so a coincident acc_clr loses
                    res_q   <= sum;
                    acc_q   <= sum;
                    state_q <= SEND;
                end
                SEND: begin
                    if (out_xfer) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= LOAD_A;
                        end
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_byte_sequencer.sv
// Self-checking bench for fadd_byte_sequencer: directed scenarios plus randomized
// transactions against a word-level reference model.
module tb_fadd_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       acc_mode = 1'b0;
    logic       acc_clr = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_acc = 32'h0;

    fadd_byte_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Keep A's sign and exponent; fraction fields add modulo 2^23.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint unsigned frac_mod;
        longint unsigned hi;
        longint unsigned frac;
        frac_mod = 64'd1 << 23;
        hi   = (longint'(a) / frac_mod) * frac_mod;
        frac = (longint'(a) % frac_mod + longint'(b) % frac_mod) % frac_mod;
        return 32'(hi + frac);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap: 0 = always valid, 1 = alternate invalid/valid, 2 = random
    task automatic push_byte(input logic [7:0] d, input int gap);
        bit done;
        bit v;
        int n;
        done = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            if (gap == 0) v = 1'b1;
            else if (gap == 1) v = (n % 2) == 1;
            else v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? d : 8'($urandom);
            #1;
            if (in_ready) chk("ready_vs_valid", {31'd0, out_valid}, 32'd0);
            if (v && in_ready) done = 1'b1;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!done) chk("in_timeout", 32'd0, 32'd1);
    endtask

    // clr_at: 0 none, 1 during EXEC, 2 during first SEND cycle
    task automatic do_txn(input bit accm, input logic [31:0] a, input logic [31:0] b,
                          input int gap, input int bp, input int clr_at, input bit rnd_out);
        logic [31:0] aeff;
        logic [31:0] expw;
        int k;
        int n;
        bit r;
        out_ready = 1'b0;
        acc_mode  = accm;
        aeff = accm ? model_acc : a;
        expw = ref_add(aeff, b);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        if (accm) begin
            chk("acc_stall_ready", {31'd0, in_ready}, 32'd0);
            step();
            chk("acc_loadb_busy", {31'd0, busy}, 32'd1);
        end else begin
            for (int i = 0; i < 4; i++) push_byte(a[8*i +: 8], gap);
        end
        for (int i = 0; i < 4; i++) push_byte(b[8*i +: 8], gap);
        chk("exec_valid", {31'd0, out_valid}, 32'd0);
        chk("exec_ready", {31'd0, in_ready}, 32'd0);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        acc_clr = (clr_at == 1);
        step();
        acc_clr = 1'b0;
        model_acc = expw;
        chk("send_latency", {31'd0, out_valid}, 32'd1);
        if (clr_at == 2) begin
            acc_clr = 1'b1;
            step();
            acc_clr = 1'b0;
            model_acc = 32'h0;
            chk("clr_send_hold", {24'd0, out_data}, {24'd0, expw[7:0]});
        end
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {24'd0, out_data}, {24'd0, expw[7:0]});
            step();
        end
        k = 0;
        n = 0;
        while (k < 4 && n < 100) begin
            r = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            #1;
            if (out_valid) chk("send_in_ready", {31'd0, in_ready}, 32'd0);
            if (r && out_valid) begin
                chk("out_byte", {24'd0, out_data}, {24'd0, expw[8*k +: 8]});
                k++;
            end
            step();
            n++;
        end
        out_ready = 1'b0;
        acc_mode  = 1'b0;
        if (k < 4) chk("out_timeout", 32'd0, 32'd1);
        if (!rnd_out) chk("out_cycles", n, 4);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready_acc0", {31'd0, in_ready}, 32'd1);
        acc_mode = 1'b1;
        #1;
        chk("rst_ready_acc1", {31'd0, in_ready}, 32'd0);
        acc_mode = 1'b0;
        rst_n = 1'b1;
        step();

        // basic, accumulate, backpressure, gaps with fraction wrap
        do_txn(1'b0, 32'h40200000, 32'h40100000, 0, 0, 0, 1'b0);
        do_txn(1'b1, 32'h0, 32'h40100000, 0, 0, 0, 1'b0);
        chk("acc_model", model_acc, 32'h40400000);
        do_txn(1'b0, 32'h40200000, 32'h40100000, 0, 5, 0, 1'b0);
        do_txn(1'b0, 32'h3FFFFFFF, 32'h3F800001, 1, 0, 0, 1'b0);

        // reset after two B bytes
        for (int i = 0; i < 4; i++) push_byte(8'h11 * 8'(i + 1), 0);
        push_byte(8'hAA, 0);
        push_byte(8'hBB, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_acc = 32'h0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        do_txn(1'b1, 32'h0, 32'h40100000, 0, 0, 0, 1'b0);

        // acc_clr colliding with EXEC, then during SEND
        do_txn(1'b0, 32'h40200000, 32'h40100000, 0, 0, 1, 1'b0);
        do_txn(1'b1, 32'h0, 32'h40100000, 0, 0, 0, 1'b0);
        do_txn(1'b0, 32'h40200000, 32'h40100000, 0, 0, 2, 1'b0);
        do_txn(1'b1, 32'h0, 32'h40100000, 0, 0, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 2,
                   $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
